// File: rtl/csidh512_pkg.sv
// Shared constants for the CSIDH-512 field arithmetic unit: field prime,
// Montgomery constants, operation codes and controller states.
package csidh512_pkg;

    localparam int CSIDH_N         = 512;
    localparam int CSIDH_WORD_SIZE = 32;

    localparam logic [CSIDH_N-1:0] CSIDH_P =
        512'h65b48e8f740f89bf_fc8ab0d15e3e4c4a_b42d083aedc88c42_5afbfcc69322c9cd_a7aac6c567f35507_516730cc1f0b4f25_c2721bf457aca835_1b81b90533c6c87b;

    // Newton iteration for m^-1 mod 2^512; each step doubles the number of
    // correct low bits, starting from 3 (m*m == 1 mod 8 for odd m).
    function automatic logic [CSIDH_N-1:0] calc_neg_inv(input logic [CSIDH_N-1:0] m);
        logic [CSIDH_N-1:0] x;
        x = m;
        for (int k = 0; k < 8; k++) begin
            x = x * (512'd2 - m * x);
        end
        return 512'd0 - x;
    endfunction

    localparam logic [CSIDH_N-1:0] CSIDH_P_INV = calc_neg_inv(CSIDH_P);
    // 2^512 lies between 2p and 3p, so R mod p is 2^512 - 2p.
    localparam logic [CSIDH_N-1:0] CSIDH_FP1   = 512'd0 - (CSIDH_P << 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_RED,
        ST_ADD,
        ST_FIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fp_mac_row.sv
// Combinational word x N multiply-accumulate: sum = acc + a * x.
module fp_mac_row #(
    parameter int N         = 512,
    parameter int word_size = 32
) (
    input  logic [N+word_size:0]   acc,
    input  logic [word_size-1:0]   a,
    input  logic [N-1:0]           x,
    output logic [N+word_size:0]   sum
);

    logic [N+word_size-1:0] prod;

    assign prod = {{N{1'b0}}, a} * {{word_size{1'b0}}, x};
    assign sum  = acc + {1'b0, prod};

endmodule

// File: rtl/fp_arith_unit.sv
// Word-serial Montgomery multiplier plus modular add/sub/pass for a prime
// field, driven by a request/acknowledge handshake on rst_mul.
//
// state | meaning
// IDLE  | waiting for rst_mul low; captures A, B, op
// MAC   | T += a_i * B, derive reduction digit q
// RED   | T = (T + q * p) >> word_size, advance digit index
// ADD   | form unreduced sum / difference / pass value in S
// FIN   | final conditional correction into mul, raise done_mul
// DONE  | hold result until rst_mul acknowledges
module fp_arith_unit
    import csidh512_pkg::*;
#(
    parameter int             N         = CSIDH_N,
    parameter int             word_size = CSIDH_WORD_SIZE,
    parameter logic [N-1:0]   p         = CSIDH_P,
    parameter logic [N-1:0]   p_inv     = CSIDH_P_INV,
    parameter logic [N-1:0]   fp1       = CSIDH_FP1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rst_mul,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [1:0]     op,
    output logic [N-1:0]   mul,
    output logic           done_mul
);

    localparam int ITERS = N / word_size;
    localparam int IW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int T_W   = N + word_size + 1;

    if (fp1 >= p || (N % word_size) != 0) begin : g_param_check
        $error("fp_arith_unit: fp1 must be reduced and N a multiple of word_size");
    end

    state_t                 state;
    logic [N-1:0]           a_reg;
    logic [N-1:0]           b_reg;
    logic [1:0]             op_reg;
    logic [T_W-1:0]         t;
    logic [N:0]             s;
    logic [IW-1:0]          i;
    logic [word_size-1:0]   q;

    logic [word_size-1:0]   mac_a;
    logic [N-1:0]           mac_x;
    logic [T_W-1:0]         mac_sum;
    logic [N-1:0]           fin_val;

    // One MAC row shared: a_i*B during MAC, q*p during RED.
    assign mac_a = (state == ST_RED) ? q : a_reg[word_size-1:0];
    assign mac_x = (state == ST_RED) ? p : b_reg;

    fp_mac_row #(
        .N         (N),
        .word_size (word_size)
    ) u_mac (
        .acc (t),
        .a   (mac_a),
        .x   (mac_x),
        .sum (mac_sum)
    );

    always_comb begin
        fin_val = s[N-1:0];
        case (op_reg)
            OP_MUL:  fin_val = (t >= {{(word_size+1){1'b0}}, p}) ? t[N-1:0] - p : t[N-1:0];
            OP_ADD:  fin_val = (s >= {1'b0, p}) ? s[N-1:0] - p : s[N-1:0];
            OP_SUB:  fin_val = s[N] ? s[N-1:0] + p : s[N-1:0];
            default: fin_val = s[N-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= OP_MUL;
            t        <= '0;
            s        <= '0;
            i        <= '0;
            q        <= '0;
            mul      <= '0;
            done_mul <= 1'b0;
        end else if (rst_mul) begin
            state    <= ST_IDLE;
            done_mul <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    a_reg  <= A;
                    b_reg  <= B;
                    op_reg <= op;
                    t      <= '0;
                    i      <= '0;
                    state  <= (op == OP_MUL) ? ST_MAC : ST_ADD;
                end
                ST_MAC: begin
                    t     <= mac_sum;
                    q     <= mac_sum[word_size-1:0] * p_inv[word_size-1:0];
                    state <= ST_RED;
                end
                ST_RED: begin
                    // Low digit of T + q*p is zero by choice of q; the shift is exact.
                    t     <= {{word_size{1'b0}}, mac_sum[T_W-1:word_size]};
                    a_reg <= a_reg >> word_size;
                    i     <= i + IW'(1);
                    state <= (i == IW'(ITERS - 1)) ? ST_FIN : ST_MAC;
                end
                ST_ADD: begin
                    case (op_reg)
                        OP_ADD:  s <= {1'b0, a_reg} + {1'b0, b_reg};
                        OP_SUB:  s <= {1'b0, a_reg} - {1'b0, b_reg};
                        default: s <= {1'b0, a_reg};
                    endcase
                    state <= ST_FIN;
                end
                ST_FIN: begin
                    mul      <= fin_val;
                    done_mul <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_arith_unit.md
FP_ARITH_UNIT -- requirements
Module: fp_arith_unit

Interface
REQ-001 Parameter N, default 512, operand/prime bit-width.
REQ-002 Parameter word_size, default 32, Montgomery digit width; N/word_size = 16 iterations.
REQ-003 Parameter p, default CSIDH-512 prime, field modulus.
REQ-004 Parameter p_inv, default (-p)^-1 mod 2^512; only the low word_size bits are used.
REQ-005 Parameter fp1, default R mod p (Montgomery one), used by the verification package only.
REQ-006 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 Port rst  input  1  reset, synchronous, active-high.
REQ-008 Port rst_mul  input  1  request control: high = idle/acknowledge, low = request operation.
REQ-009 Port A  input  N  first operand, reduced (< p).
REQ-010 Port B  input  N  second operand, reduced (< p).
REQ-011 Port op  input  2  00 = Montgomery multiply A*B*R^-1 mod p; 01 = A+B mod p; 10 = A-B mod p; 11 = pass A.
REQ-012 Port mul  output  N  registered result, fully reduced (< p).
REQ-013 Port done_mul  output  1  registered; high = mul is valid.

Function
REQ-014 States: IDLE, MAC, RED, ADD, FIN, DONE.
REQ-015 IDLE: on an edge sampling rst_mul=0, capture A, B, op into internal registers, clear accumulator T and index i; go to MAC if op=00, else ADD.
REQ-016 Operands are used only from the captured registers; A/B/op changes after the capture edge have no effect.
REQ-017 MAC: T <= T + a_i*B; q <= ((T0 + a_i0*B0) * p_inv) mod 2^word_size; go to RED.
REQ-018 RED: T <= (T + q*p) >> word_size; i <= i+1; go to MAC if i<15, else FIN.
REQ-019 T is N+word_size+1 bits wide; no intermediate truncation.
REQ-020 ADD: op=01 S <= A+B (N+1 bits); op=10 S <= A-B (N+1 bits, two's complement); op=11 S <= A; go to FIN.
REQ-021 FIN: mul <= T-p if T>=p else T (multiply); S-p if S>=p else S (add); S+p if S negative else S (sub); S (pass); done_mul <= 1; go to DONE.
REQ-022 Latency: counting the capture edge as edge 1, done_mul is high after edge 34 for multiply and after edge 3 for add/sub/pass.
REQ-023 DONE: mul and done_mul held stable while rst_mul=0.
REQ-024 Any edge sampling rst_mul=1 in any state: done_mul <= 0, state <= IDLE; mul keeps its last value; an in-flight operation is abandoned with no output update.
REQ-025 A new request is accepted only from IDLE; with rst_mul low continuously after DONE, no second operation starts.
REQ-026 The cycle after an acknowledging rst_mul=1, done_mul is 0, so an initiator that drops rst_mul on the next edge never sees a stale done.

Reset
REQ-027 rst=1 at an edge: state IDLE, done_mul 0, mul 0, T/S/i/q cleared; rst overrides rst_mul.
REQ-028 rst mid-operation abandons it; the first request after rst deasserts behaves as from power-up.

Structure
REQ-029 Shared package csidh512_pkg holds N, word_size, p, p_inv, fp1, the op encodings (OP_MUL, OP_ADD, OP_SUB, OP_PASS), and the state enumeration.
REQ-030 One sub-module, fp_mac_row: combinational word_size x N multiply-accumulate (T + a*X), instantiated for a_i*B and q*p terms or time-shared between MAC and RED.

Verification
REQ-031 op=00, A=B=fp1 -> mul=fp1, done_mul rises after edge 34.
REQ-032 op=01, A=p-1, B=1 -> mul=0 after edge 3; A=2, B=3 -> mul=5.
REQ-033 op=10, A=0, B=1 -> mul=p-1; A=5, B=5 -> mul=0.
REQ-034 op=00, A=x (random < p), B=fp1 -> mul=x; 1000 random pairs checked against reference model A*B*2^-512 mod p.
REQ-035 rst_mul raised at edge 10 of a multiply -> done_mul stays 0, mul unchanged; next request completes correctly.
REQ-036 Back-to-back initiator handshake (drop rst_mul, capture on done_mul, raise rst_mul one cycle, drop again) for 4 chained ops -> each result correct, no done_mul observed while rst_mul was high the previous edge.
